// File: rtl/regbank_read_arbiter_pkg.sv
// Shared constants, state encoding and width helpers for the register-bank read arbiter.
package regbank_read_arbiter_pkg;

   localparam int N_REQ           = 3;
   localparam int REQ_DECODE      = 0;
   localparam int REQ_FETCH       = 1;
   localparam int REQ_ISSUE       = 2;
   localparam int DEFAULT_TIMEOUT = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ERROR = 2'd3
   } state_t;

   // Width able to index n requesters; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Width able to hold 0..t; a disabled timeout (t == 0) still gets one bit.
   function automatic int cnt_width(input int t);
      return (t <= 0) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/regbank_read_arbiter_if.sv
// Requester and register-bank toggle-handshake bundle around the read arbiter.
interface regbank_read_arbiter_if #(
   parameter int N_REQ  = regbank_read_arbiter_pkg::N_REQ,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic [N_REQ-1:0]        reqTrigger;
   logic [N_REQ*ADDR_W-1:0] reqAddr;
   logic [N_REQ-1:0]        reqReady;
   logic [DATA_W-1:0]       dataOut;
   logic                    triggerOutRB;
   logic [ADDR_W-1:0]       addrRB;
   logic                    readyInRB;
   logic [DATA_W-1:0]       dataInRB;
   logic                    busy;
   logic                    errOut;

   // Arbiter side.
   modport slave (
      input  reqTrigger, reqAddr, readyInRB, dataInRB,
      output reqReady, dataOut, triggerOutRB, addrRB, busy, errOut
   );

   // Requesters plus register bank side.
   modport master (
      output reqTrigger, reqAddr, readyInRB, dataInRB,
      input  reqReady, dataOut, triggerOutRB, addrRB, busy, errOut
   );

endinterface

// File: rtl/regbank_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index at or after i_ptr, wrapping modulo N.
module rr_pick
   import regbank_read_arbiter_pkg::*;
#(
   parameter int N     = N_REQ,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     i_pending,
   input  logic [IDX_W-1:0] i_ptr,
   output logic             o_valid,
   output logic [IDX_W-1:0] o_index
);

   logic [IDX_W:0]   w_sum  [N];
   logic [IDX_W-1:0] w_cand [N];
   logic [N-1:0]     w_hit;

   // i_ptr < N and offset < N, so a single conditional subtract performs the wrap.
   for (genvar gi = 0; gi < N; gi++) begin : g_cand
      assign w_sum[gi]  = {1'b0, i_ptr} + (IDX_W+1)'(gi);
      assign w_cand[gi] = (w_sum[gi] >= (IDX_W+1)'(N)) ?
                          IDX_W'(w_sum[gi] - (IDX_W+1)'(N)) : IDX_W'(w_sum[gi]);
      assign w_hit[gi]  = i_pending[w_cand[gi]];
   end

   always_comb begin
      o_valid = |w_hit;
      o_index = w_cand[0];
      for (int k = N - 1; k >= 0; k--) begin
         if (w_hit[k]) begin
            o_index = w_cand[k];
         end
      end
   end

endmodule

// File: rtl/regbank_read_arbiter.sv
// Round-robin arbiter sharing the single register-bank read port among toggle-handshake requesters,
// with a sticky timeout trap for a bank that never answers.
module regbank_read_arbiter #(
   parameter int N_REQ   = regbank_read_arbiter_pkg::N_REQ,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = regbank_read_arbiter_pkg::DEFAULT_TIMEOUT
) (
   input  logic                 clk,
   input  logic                 reset,
   regbank_read_arbiter_if.slave bus
);

   import regbank_read_arbiter_pkg::*;

   localparam int IDX_W = idx_width(N_REQ);
   localparam int CNT_W = cnt_width(TIMEOUT);

   state_t              r_state;
   logic [N_REQ-1:0]    r_req_ready;
   logic [DATA_W-1:0]   r_data_out;
   logic                r_trigger_rb;
   logic [ADDR_W-1:0]   r_addr_rb;
   logic [IDX_W-1:0]    r_grant;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic                r_busy;
   logic                r_err;
   logic [CNT_W-1:0]    r_cnt;

   logic [N_REQ-1:0]    w_pending;
   logic                w_pick_valid;
   logic [IDX_W-1:0]    w_pick_idx;
   logic [IDX_W-1:0]    w_next_ptr;
   logic                w_bank_done;
   logic                w_timeout_hit;
   logic [ADDR_W-1:0]   w_req_addr [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
      assign w_req_addr[gi] = bus.reqAddr[gi*ADDR_W +: ADDR_W];
   end

   assign w_pending     = bus.reqTrigger ^ r_req_ready;
   assign w_bank_done   = (bus.readyInRB == r_trigger_rb);
   assign w_next_ptr    = (r_grant == IDX_W'(N_REQ - 1)) ? '0 : r_grant + IDX_W'(1);
   assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

   rr_pick #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .i_pending (w_pending),
      .i_ptr     (r_rr_ptr),
      .o_valid   (w_pick_valid),
      .o_index   (w_pick_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_req_ready  <= '0;
         r_data_out   <= '0;
         r_trigger_rb <= 1'b0;
         r_addr_rb    <= '0;
         r_grant      <= '0;
         r_rr_ptr     <= '0;
         r_busy       <= 1'b0;
         r_err        <= 1'b0;
         r_cnt        <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pick_valid) begin
                  r_grant   <= w_pick_idx;
                  r_addr_rb <= w_req_addr[w_pick_idx];
                  r_busy    <= 1'b1;
                  r_state   <= ISSUE;
               end
            end
            ISSUE: begin
               r_trigger_rb <= ~r_trigger_rb;
               r_cnt        <= '0;
               r_state      <= WAIT;
            end
            WAIT: begin
               if (w_bank_done) begin
                  r_data_out           <= bus.dataInRB;
                  r_req_ready[r_grant] <= ~r_req_ready[r_grant];
                  r_rr_ptr             <= w_next_ptr;
                  r_busy               <= 1'b0;
                  r_state              <= IDLE;
               end else if (w_timeout_hit) begin
                  r_busy  <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= ERROR;
               end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ERROR: begin
               // Terminal until reset: late bank toggles and new requests are ignored.
               r_busy <= 1'b0;
               r_err  <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.reqReady     = r_req_ready;
   assign bus.dataOut      = r_data_out;
   assign bus.triggerOutRB = r_trigger_rb;
   assign bus.addrRB       = r_addr_rb;
   assign bus.busy         = r_busy;
   assign bus.errOut       = r_err;

endmodule

// File: tb/tb_regbank_read_arbiter.sv
// Scenario bench for the register-bank read arbiter with a behavioural bank and completion scoreboard.
module tb_regbank_read_arbiter;

   import regbank_read_arbiter_pkg::*;

   localparam int NR = N_REQ;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   regbank_read_arbiter_if #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

   regbank_read_arbiter #(
      .N_REQ   (NR),
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Bank model state: latency in cycles, mute switch, log of every address the bank was asked for.
   int          bank_lat  = 1;
   bit          bank_mute = 1'b0;
   int          bank_cnt  = -1;
   logic        bank_seen;
   logic [AW-1:0] bank_addr;
   logic [AW-1:0] bank_q [$];
   int          done_q [$];

   function automatic logic [DW-1:0] bank_data(input logic [AW-1:0] a);
      if (a == 32'h0000_000F) return 32'h0000_1234;
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   initial begin : bank_model
      bank_seen     = 1'b0;
      bus.readyInRB = 1'b0;
      bus.dataInRB  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            bank_seen     = 1'b0;
            bank_cnt      = -1;
            bus.readyInRB = 1'b0;
         end else begin
            if (bus.triggerOutRB !== bank_seen) begin
               bank_seen = bus.triggerOutRB;
               bank_addr = bus.addrRB;
               bank_q.push_back(bus.addrRB);
               bank_cnt  = bank_lat;
            end else if (bank_cnt > 0) begin
               bank_cnt--;
            end
            if (bank_cnt == 0) begin
               if (!bank_mute) begin
                  bus.dataInRB  = bank_data(bank_addr);
                  bus.readyInRB = bank_seen;
               end
               bank_cnt = -1;
            end
         end
      end
   end

   // Every reqReady toggle must complete a pending request and carry the bank's data for its address.
   initial begin : scoreboard
      logic [NR-1:0] prev;
      prev = '0;
      forever begin
         @(posedge clk);
         #2;
         if (!reset) begin
            for (int i = 0; i < NR; i++) begin
               if (bus.reqReady[i] !== prev[i]) begin
                  done_q.push_back(i);
                  checks++;
                  if (bus.dataOut !== bank_data(bus.reqAddr[i*AW +: AW]) ||
                      bus.reqReady[i] !== bus.reqTrigger[i]) begin
                     errors++;
                     $display("FAIL completion req%0d: dataOut=%h ready=%b trigger=%b, required dataOut=%h ready==trigger",
                              i, bus.dataOut, bus.reqReady[i], bus.reqTrigger[i], bank_data(bus.reqAddr[i*AW +: AW]));
                  end
               end
            end
         end
         prev = bus.reqReady;
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic raise(input int i, input logic [AW-1:0] a);
      bus.reqAddr[i*AW +: AW] = a;
      bus.reqTrigger[i]       = ~bus.reqTrigger[i];
   endtask

   task automatic wait_done(input int i, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (bus.reqReady[i] === bus.reqTrigger[i]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_all_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (bus.reqReady === bus.reqTrigger) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset          = 1'b1;
      bus.reqTrigger = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({bus.reqReady, bus.triggerOutRB, bus.addrRB, bus.dataOut, bus.busy, bus.errOut} !== '0) begin
         errors++;
         $display("FAIL reset_values: ready=%b trig=%b addr=%h data=%h busy=%b err=%b, required all zero",
                  bus.reqReady, bus.triggerOutRB, bus.addrRB, bus.dataOut, bus.busy, bus.errOut);
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.triggerOutRB !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b trig=%b, required 0 0", bus.busy, bus.triggerOutRB);
      end
   endtask

   task automatic test_single();
      logic [NR-1:0] rdy0;
      logic          trg0;
      bit            ok;
      @(negedge clk);
      bank_lat = 2;
      bank_q.delete();
      rdy0 = bus.reqReady;
      trg0 = bus.triggerOutRB;
      raise(REQ_FETCH, 32'h0000_000F);
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1 || bus.triggerOutRB !== trg0) begin
         errors++;
         $display("FAIL single_issue: busy=%b trig=%b, required busy=1 trig=%b", bus.busy, bus.triggerOutRB, trg0);
      end
      @(negedge clk);
      checks++;
      if (bus.triggerOutRB !== ~trg0 || bus.addrRB !== 32'h0000_000F) begin
         errors++;
         $display("FAIL single_trigger: trig=%b addr=%h, required trig=%b addr=0000000f", bus.triggerOutRB, bus.addrRB, ~trg0);
      end
      wait_done(REQ_FETCH, 20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_done: reqReady[1] never toggled within 20 cycles");
      end
      checks++;
      if (bus.dataOut !== 32'h0000_1234 || bus.reqReady !== (rdy0 ^ 3'b010)) begin
         errors++;
         $display("FAIL single_data: data=%h ready=%b, required data=00001234 ready=%b", bus.dataOut, bus.reqReady, rdy0 ^ 3'b010);
      end
      checks++;
      if (bank_q.size() != 1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL single_after: bank reads=%0d busy=%b, required 1 read and busy=0", bank_q.size(), bus.busy);
      end
   endtask

   task automatic test_contention();
      bit ok;
      int d0;
      do_reset();
      bank_lat = 1;
      bank_q.delete();
      d0 = done_q.size();
      raise(REQ_DECODE, 32'd1);
      raise(REQ_FETCH,  32'd2);
      raise(REQ_ISSUE,  32'd3);
      wait_all_done(80, ok);
      checks++;
      if (!ok || bank_q.size() != 3 || done_q.size() - d0 != 3) begin
         errors++;
         $display("FAIL contention_count: ok=%0d bank reads=%0d completions=%0d, required 3 and 3", ok, bank_q.size(), done_q.size() - d0);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (bank_q[i] !== AW'(i + 1) || done_q[d0 + i] != i) begin
               errors++;
               $display("FAIL contention_order[%0d]: bank addr=%h served=%0d, required addr=%h served=%0d", i, bank_q[i], done_q[d0 + i], i + 1, i);
            end
         end
      end
   endtask

   task automatic test_fairness();
      int  d0;
      int  rounds;
      bit  ok;
      do_reset();
      bank_lat = 2;
      bank_q.delete();
      d0 = done_q.size();
      rounds = 2;
      raise(REQ_DECODE, 32'h100);
      ok = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bank_q.size() == 1) begin ok = 1'b1; break; end
      end
      raise(REQ_ISSUE, 32'h300);
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (bus.reqReady[REQ_DECODE] === bus.reqTrigger[REQ_DECODE] && rounds > 0) begin
            raise(REQ_DECODE, AW'(32'h100 + rounds));
            rounds--;
         end else if (rounds == 0 && bus.reqReady === bus.reqTrigger) begin
            break;
         end
      end
      checks++;
      if (!ok || done_q.size() - d0 != 4) begin
         errors++;
         $display("FAIL fairness_count: first grant seen=%0d completions=%0d, required 1 and 4", ok, done_q.size() - d0);
      end else begin
         checks++;
         if (done_q[d0] != REQ_DECODE || done_q[d0 + 1] != REQ_ISSUE || bank_q[1] !== 32'h300) begin
            errors++;
            $display("FAIL fairness_order: served %0d then %0d (2nd addr %h), required 0 then 2 (addr 00000300)",
                     done_q[d0], done_q[d0 + 1], bank_q[1]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic trg;
      bit   ok;
      @(negedge clk);
      bank_lat = 1;
      bank_q.delete();
      raise(REQ_DECODE, 32'hB0);
      wait_done(REQ_DECODE, 20, ok);
      trg = bus.triggerOutRB;
      raise(REQ_DECODE, 32'hB1);
      repeat (2) @(negedge clk);
      checks++;
      if (!ok || bus.triggerOutRB !== ~trg || bus.addrRB !== 32'hB1) begin
         errors++;
         $display("FAIL b2b_regrant: first ok=%0d trig=%b addr=%h, required ok=1 trig=%b addr=000000b1", ok, bus.triggerOutRB, bus.addrRB, ~trg);
      end
      wait_done(REQ_DECODE, 20, ok);
      checks++;
      if (!ok || bus.dataOut !== bank_data(32'hB1) || bank_q.size() != 2) begin
         errors++;
         $display("FAIL b2b_data: ok=%0d data=%h reads=%0d, required ok=1 data=%h reads=2", ok, bus.dataOut, bank_q.size(), bank_data(32'hB1));
      end
   endtask

   task automatic test_random();
      bit            waiting [NR];
      int            others  [NR];
      int            seen;
      int            raised;
      int            d0;
      int            id;
      bit            ok;
      logic [AW-1:0] a;
      @(negedge clk);
      bank_q.delete();
      seen   = 0;
      raised = 0;
      d0     = done_q.size();
      for (int i = 0; i < NR; i++) begin waiting[i] = 1'b0; others[i] = 0; end
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         while (bank_q.size() > seen) begin
            a  = bank_q[seen];
            seen++;
            id = int'(a[AW-1 -: 2]);
            checks++;
            if (id >= NR || !waiting[id] || a !== bus.reqAddr[id*AW +: AW] || others[id] > NR) begin
               errors++;
               $display("FAIL random_grant: bank addr=%h, required a pending requester's address granted within %0d others", a, NR);
            end else begin
               waiting[id] = 1'b0;
               for (int j = 0; j < NR; j++) if (waiting[j]) others[j]++;
            end
         end
         if (cyc < 360) begin
            for (int i = 0; i < NR; i++) begin
               if (!waiting[i] && bus.reqReady[i] === bus.reqTrigger[i] && $urandom_range(0, 2) == 0) begin
                  raise(i, {i[1:0], 30'($urandom)});
                  waiting[i] = 1'b1;
                  others[i]  = 0;
                  raised++;
               end
            end
         end
         bank_lat = int'($urandom_range(0, 4));
      end
      wait_all_done(100, ok);
      checks++;
      if (!ok || done_q.size() - d0 != raised) begin
         errors++;
         $display("FAIL random_total: drained=%0d completions=%0d, required drained=1 completions=%0d", ok, done_q.size() - d0, raised);
      end
   endtask

   task automatic test_reset_mid_wait();
      bit ok;
      @(negedge clk);
      bank_mute = 1'b1;
      bank_q.delete();
      raise(REQ_FETCH, 32'h77);
      repeat (3) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1 || bank_q.size() != 1) begin
         errors++;
         $display("FAIL midwait_setup: busy=%b reads=%0d, required busy=1 reads=1", bus.busy, bank_q.size());
      end
      reset          = 1'b1;
      bus.reqTrigger = '0;
      @(negedge clk);
      checks++;
      if ({bus.reqReady, bus.triggerOutRB, bus.addrRB, bus.dataOut, bus.busy, bus.errOut} !== '0) begin
         errors++;
         $display("FAIL midwait_reset: ready=%b trig=%b addr=%h data=%h busy=%b err=%b, required all zero",
                  bus.reqReady, bus.triggerOutRB, bus.addrRB, bus.dataOut, bus.busy, bus.errOut);
      end
      @(negedge clk);
      reset     = 1'b0;
      bank_mute = 1'b0;
      bank_lat  = 1;
      raise(REQ_ISSUE, 32'h55);
      wait_done(REQ_ISSUE, 20, ok);
      checks++;
      if (!ok || bus.dataOut !== bank_data(32'h55) || bank_q[bank_q.size() - 1] !== 32'h55) begin
         errors++;
         $display("FAIL midwait_fresh: ok=%0d data=%h, required ok=1 data=%h", ok, bus.dataOut, bank_data(32'h55));
      end
   endtask

   task automatic test_timeout();
      logic [NR-1:0] rdy0;
      logic          trg0;
      int            n;
      bit            ok;
      @(negedge clk);
      bank_mute = 1'b1;
      bank_q.delete();
      rdy0 = bus.reqReady;
      trg0 = bus.triggerOutRB;
      raise(REQ_ISSUE, 32'h2A);
      ok = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.triggerOutRB !== trg0) begin ok = 1'b1; break; end
      end
      n = 0;
      while (bus.errOut !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!ok || n != TO) begin
         errors++;
         $display("FAIL timeout_latency: trigger seen=%0d errOut after %0d cycles, required 1 and %0d", ok, n, TO);
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.reqReady !== rdy0) begin
         errors++;
         $display("FAIL timeout_state: busy=%b ready=%b, required busy=0 ready=%b", bus.busy, bus.reqReady, rdy0);
      end
      trg0 = bus.triggerOutRB;
      raise(REQ_DECODE, 32'h44);
      repeat (20) @(negedge clk);
      checks++;
      if (bus.triggerOutRB !== trg0 || bus.reqReady !== rdy0 || bus.errOut !== 1'b1 || bank_q.size() != 1) begin
         errors++;
         $display("FAIL timeout_sticky: trig=%b ready=%b err=%b reads=%0d, required trig=%b ready=%b err=1 reads=1",
                  bus.triggerOutRB, bus.reqReady, bus.errOut, bank_q.size(), trg0, rdy0);
      end
      bank_mute = 1'b0;
      do_reset();
      checks++;
      if (bus.errOut !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear: err=%b busy=%b, required 0 0", bus.errOut, bus.busy);
      end
      bank_lat = 3;
      raise(REQ_DECODE, 32'h66);
      wait_done(REQ_DECODE, 20, ok);
      checks++;
      if (!ok || bus.dataOut !== bank_data(32'h66) || bus.errOut !== 1'b0) begin
         errors++;
         $display("FAIL timeout_recover: ok=%0d data=%h err=%b, required ok=1 data=%h err=0", ok, bus.dataOut, bus.errOut, bank_data(32'h66));
      end
   endtask

   initial begin : main
      bus.reqTrigger = '0;
      bus.reqAddr    = '0;
      reset          = 1'b1;
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_back_to_back();
      test_random();
      test_reset_mid_wait();
      test_timeout();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
